video_mode_ctrl: RTL and testbench
==================================

# video_mode_ctrl

Frame-synchronous mode controller for the video processing path. It sits beside the grayscale converter. It delays the raw RGB stream and its sync signals to match the converter's pipeline latency. It then selects one of four output modes per frame (bypass, gray, binary, blank). Mode changes requested by the host are applied only at a frame boundary, so no frame is ever torn. Optional frame statistics report the measured frame geometry.

## Interface
- GRAY_LAT, 3: latency in clk cycles from rgb_in to the matching gray_in sample; valid range 1..8.
- W_CNT, 12: width of the pixel and line counters.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- rgb_in  in  24  raw pixel {R,G,B}.
- de_in / vs_in / hs_in  in  1 each  raw stream syncs, aligned with rgb_in.
- gray_in  in  24  converter output; luma is in [23:16] and arrives GRAY_LAT cycles after rgb_in.
- mode_req  in  2  requested mode: 0 bypass, 1 gray, 2 binary, 3 blank.
- thr_req  in  8  binary threshold, carried with mode_req.
- mode_req_vld  in  1  request valid.
- mode_req_rdy  out  1  controller can accept a request.
- mode_cur  out  2  mode applied to the current output frame.
- dout  out  24  output pixel.
- de_out / vs_out / hs_out  out  1 each  output syncs.
- frame_done  out  1  one-cycle pulse at each output frame start (stats build only).
- frame_w / frame_h  out  W_CNT each  pixels per line and lines of the last frame (stats build only).
- frame_err  out  1  sticky flag: line width was inconsistent within a frame (stats build only).

## Operation
- Delay line: rgb_in, de_in, vs_in and hs_in each pass through a GRAY_LAT-deep shift register, producing rgb_d, de_d, vs_d and hs_d, which are aligned with gray_in.
- vs_d rising edge (vs_d=1 and the previous vs_d=0) defines the frame edge.
- State machine:
  - S_IDLE: entered on reset. Outputs are forced to 0. On the first frame edge, go to S_ACTIVE and apply any pending request.
  - S_ACTIVE: stays here until reset.
- Request handshake:
  - A request is accepted when mode_req_vld && mode_req_rdy. mode_req and thr_req are then captured into a pending register, and rdy drops the next cycle.
  - At the next frame edge, pending is copied to mode_cur/thr_cur and rdy rises.
  - A request accepted in the same cycle as a frame edge waits for the following frame edge.
  - Holding vld high with rdy low has no effect.
- Pixel select, registered into dout:
  - bypass: rgb_d.
  - gray: {g,g,g}, where g = gray_in[23:16].
  - binary: 24'hFFFFFF if g > thr_cur, else 0. Equality gives 0.
  - blank: 0.
  - dout = 0 whenever de_d = 0.
- de_out, vs_out and hs_out are the registered de_d, vs_d and hs_d, regardless of mode.
- Frame edge timing: the output register already uses the new mode in the edge cycle's output, which is the first cycle with vs_out=1.
- Statistics:
  - pix_cnt increments on each cycle with de_d=1.
  - On a de_d falling edge: line_cnt increments, pix_cnt is compared against the first line width of the frame (mismatch sets frame_err), and pix_cnt clears.
  - On a frame edge: frame_w is loaded with the first-line width, frame_h with line_cnt, and frame_done pulses. The counters then clear.
  - Counters saturate at all-ones and do not wrap.
  - frame_err clears only on reset.

## Timing
- Latency from rgb_in to dout is GRAY_LAT+1 cycles; the syncs have the same latency.
- Reset values:
  - dout, de_out, vs_out, hs_out, mode_cur, frame_done, frame_w, frame_h, frame_err: 0.
  - mode_req_rdy: 1.
  - thr_cur: 8'd128.
  - State: S_IDLE.
- Reset asserted mid-frame clears the delay line and all state asynchronously. Output stays blank until the next full frame edge.
- frame_done is asserted in the same cycle as the frame edge, one cycle before vs_out rises.

## Configuration
- VIDEO_MODE_CTRL_STATS_EN:
  - Defined: counters, frame_w, frame_h, frame_done and frame_err are implemented.
  - Undefined: these outputs are tied to 0 and no counter logic is synthesized. The mode path is unchanged.

## Test plan
- Reset, then drive 4x3 frames in bypass with rgb_in=24'h123456. Required: dout=24'h123456 exactly GRAY_LAT+1 cycles after de_in, and nothing is output before the first vs_d edge.
- In mid frame, request mode=1. Required: rdy drops, the current frame is still bypass, and the next frame is {g,g,g} with g=gray_in[23:16], while rdy=1 again.
- Request mode=2, thr=100, with g values 99/100/101. Required: dout = 0, 0, FFFFFF respectively.
- Make the request acceptance coincide with the frame edge. Required: mode_cur changes only at the following edge.
- Stats build, 4x3 frame, then one frame with a 5-pixel line. Required: frame_done pulse with frame_w=4, frame_h=3; then frame_err=1 and it stays 1.
- Assert rst_n=0 mid-line. Required: all outputs 0 immediately, rdy=1, mode_cur=0.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Frame-synchronous output mode controller: aligns raw RGB/syncs with the grayscale converter
// and applies host mode changes only at frame edges. Define VIDEO_MODE_CTRL_STATS_EN for frame statistics.
module video_mode_ctrl #(
    parameter int GRAY_LAT = 3,
    parameter int W_CNT    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      rgb_in,
    input  logic             de_in,
    input  logic             vs_in,
    input  logic             hs_in,
    input  logic [23:0]      gray_in,
    input  logic [1:0]       mode_req,
    input  logic [7:0]       thr_req,
    input  logic             mode_req_vld,
    output logic             mode_req_rdy,
    output logic [1:0]       mode_cur,
    output logic [23:0]      dout,
    output logic             de_out,
    output logic             vs_out,
    output logic             hs_out,
    output logic             frame_done,
    output logic [W_CNT-1:0] frame_w,
    output logic [W_CNT-1:0] frame_h,
    output logic             frame_err
);
    // state    | meaning
    // S_IDLE   | after reset, outputs held at 0 until the first frame edge
    // S_ACTIVE | streaming with the applied mode
    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    logic [23:0]         r_rgb_sr [GRAY_LAT];
    logic [GRAY_LAT-1:0] r_de_sr, r_vs_sr, r_hs_sr;
    logic [23:0]         w_rgb_d;
    logic                w_de_d, w_vs_d, w_hs_d;
    logic                r_vs_d_q, w_frame_edge;
    state_t              r_state, w_state_nxt;
    logic                r_rdy;
    logic [1:0]          r_pend_mode, r_mode_cur, w_mode_eff;
    logic [7:0]          r_pend_thr, r_thr_cur, w_thr_eff, w_g;
    logic                w_apply, w_out_en;
    logic [23:0]         w_pix, r_dout;
    logic                r_de_out, r_vs_out, r_hs_out;
    logic                w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GRAY_LAT; i++) r_rgb_sr[i] <= '0;
            r_de_sr  <= '0;
            r_vs_sr  <= '0;
            r_hs_sr  <= '0;
            r_vs_d_q <= 1'b0;
        end else begin
            r_rgb_sr[0] <= rgb_in;
            r_de_sr[0]  <= de_in;
            r_vs_sr[0]  <= vs_in;
            r_hs_sr[0]  <= hs_in;
            for (int i = 1; i < GRAY_LAT; i++) begin
                r_rgb_sr[i] <= r_rgb_sr[i-1];
                r_de_sr[i]  <= r_de_sr[i-1];
                r_vs_sr[i]  <= r_vs_sr[i-1];
                r_hs_sr[i]  <= r_hs_sr[i-1];
            end
            r_vs_d_q <= w_vs_d;
        end
    end

    assign w_rgb_d      = r_rgb_sr[GRAY_LAT-1];
    assign w_de_d       = r_de_sr[GRAY_LAT-1];
    assign w_vs_d       = r_vs_sr[GRAY_LAT-1];
    assign w_hs_d       = r_hs_sr[GRAY_LAT-1];
    assign w_frame_edge = w_vs_d & ~r_vs_d_q;
    assign w_g          = gray_in[23:16];
    assign w_unused     = ^gray_in[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The edge cycle already selects with the pending mode so vs_out's first cycle is in the new mode.
    always_comb begin
        w_state_nxt = r_state;
        w_out_en    = 1'b0;
        w_apply     = w_frame_edge && !r_rdy;
        w_mode_eff  = r_mode_cur;
        w_thr_eff   = r_thr_cur;
        w_pix       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_frame_edge) begin
                    w_state_nxt = S_ACTIVE;
                    w_out_en    = 1'b1;
                end
            end
            S_ACTIVE: w_out_en = 1'b1;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_apply) begin
            w_mode_eff = r_pend_mode;
            w_thr_eff  = r_pend_thr;
        end
        if (w_de_d) begin
            case (w_mode_eff)
                2'd0:    w_pix = w_rgb_d;
                2'd1:    w_pix = {w_g, w_g, w_g};
                2'd2:    w_pix = (w_g > w_thr_eff) ? 24'hFFFFFF : 24'h000000;
                default: w_pix = '0;
            endcase
        end
    end

    // A request accepted on the edge cycle itself waits for the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy       <= 1'b1;
            r_pend_mode <= 2'd0;
            r_pend_thr  <= 8'd0;
            r_mode_cur  <= 2'd0;
            r_thr_cur   <= 8'd128;
        end else if (w_apply) begin
            r_mode_cur <= r_pend_mode;
            r_thr_cur  <= r_pend_thr;
            r_rdy      <= 1'b1;
        end else if (mode_req_vld && r_rdy) begin
            r_pend_mode <= mode_req;
            r_pend_thr  <= thr_req;
            r_rdy       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_de_out <= 1'b0;
            r_vs_out <= 1'b0;
            r_hs_out <= 1'b0;
        end else if (w_out_en) begin
            r_dout   <= w_pix;
            r_de_out <= w_de_d;
            r_vs_out <= w_vs_d;
            r_hs_out <= w_hs_d;
        end else begin
            r_dout   <= '0;
            r_de_out <= 1'b0;
            r_vs_out <= 1'b0;
            r_hs_out <= 1'b0;
        end
    end

    assign dout         = r_dout;
    assign de_out       = r_de_out;
    assign vs_out       = r_vs_out;
    assign hs_out       = r_hs_out;
    assign mode_req_rdy = r_rdy;
    assign mode_cur     = r_mode_cur;

`ifdef VIDEO_MODE_CTRL_STATS_EN
    localparam logic [W_CNT-1:0] CNT_MAX = '1;

    logic [W_CNT-1:0] r_pix_cnt, r_line_cnt, r_first_w, r_frame_w, r_frame_h;
    logic             r_first_vld, r_de_d_q, r_frame_err, w_line_end;

    assign w_line_end = r_de_d_q & ~w_de_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_first_w   <= '0;
            r_first_vld <= 1'b0;
            r_de_d_q    <= 1'b0;
            r_frame_w   <= '0;
            r_frame_h   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_de_d_q <= w_de_d;
            if (w_frame_edge) begin
                r_frame_w   <= r_first_w;
                r_frame_h   <= r_line_cnt;
                r_pix_cnt   <= '0;
                r_line_cnt  <= '0;
                r_first_w   <= '0;
                r_first_vld <= 1'b0;
            end else if (w_line_end) begin
                if (r_line_cnt != CNT_MAX) r_line_cnt <= r_line_cnt + W_CNT'(1);
                if (!r_first_vld) begin
                    r_first_w   <= r_pix_cnt;
                    r_first_vld <= 1'b1;
                end else if (r_pix_cnt != r_first_w) begin
                    r_frame_err <= 1'b1;
                end
                r_pix_cnt <= '0;
            end else if (w_de_d && (r_pix_cnt != CNT_MAX)) begin
                r_pix_cnt <= r_pix_cnt + W_CNT'(1);
            end
        end
    end

    assign frame_done = w_frame_edge;
    assign frame_w    = r_frame_w;
    assign frame_h    = r_frame_h;
    assign frame_err  = r_frame_err;
`else
    assign frame_done = 1'b0;
    assign frame_w    = '0;
    assign frame_h    = '0;
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: queue-based reference model checked every cycle, plus literal
// expectations for latency, gray/binary selection, edge-coincident requests, stats and reset.
`timescale 1ns/1ps
module tb_video_mode_ctrl;
    localparam int L     = 3;
    localparam int W_CNT = 12;
    localparam int FS    = (L + 2 > 4) ? L + 2 : 4;
`ifdef VIDEO_MODE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [23:0]      rgb_in = '0;
    logic [23:0]      gray_in;
    logic             de_in = 1'b0, vs_in = 1'b0, hs_in = 1'b0;
    logic [1:0]       mode_req = '0;
    logic [7:0]       thr_req = '0;
    logic             mode_req_vld = 1'b0;
    logic             mode_req_rdy;
    logic [1:0]       mode_cur;
    logic [23:0]      dout;
    logic             de_out, vs_out, hs_out, frame_done, frame_err;
    logic [W_CNT-1:0] frame_w, frame_h;

    always #5 clk = ~clk;

    video_mode_ctrl #(.GRAY_LAT(L), .W_CNT(W_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .de_in(de_in), .vs_in(vs_in), .hs_in(hs_in),
        .gray_in(gray_in), .mode_req(mode_req), .thr_req(thr_req), .mode_req_vld(mode_req_vld),
        .mode_req_rdy(mode_req_rdy), .mode_cur(mode_cur), .dout(dout), .de_out(de_out),
        .vs_out(vs_out), .hs_out(hs_out), .frame_done(frame_done), .frame_w(frame_w),
        .frame_h(frame_h), .frame_err(frame_err)
    );

    // Stand-in converter: luma is the R byte, low bytes carry junk the DUT must ignore.
    logic [23:0] cv [L];
    initial for (int i = 0; i < L; i++) cv[i] = '0;
    always @(posedge clk) begin
        cv[0] <= rgb_in;
        for (int i = 1; i < L; i++) cv[i] <= cv[i-1];
    end
    assign gray_in = {cv[L-1][23:16], cv[L-1][7:0] ^ 8'h5A, cv[L-1][15:8]};

    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: inputs delayed by a queue of L samples, mode/pending as plain variables.
    logic [26:0] m_q[$];
    logic [26:0] m_d;
    bit          m_active, m_has_pend, m_prev_vs, m_prev_de, m_fe, m_acc;
    logic [1:0]  m_mode, m_pmode;
    logic [7:0]  m_thr, m_pthr, m_g;
    logic [23:0] e_dout;
    bit          e_de, e_vs, e_hs, e_err;
    int          m_pix;
    int          m_widths[$];
    logic [W_CNT-1:0] e_fw, e_fh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < L; i++) m_q.push_back('0);
            m_active = 0; m_has_pend = 0; m_prev_vs = 0; m_prev_de = 0;
            m_mode = 2'd0; m_thr = 8'd128; m_pmode = 2'd0; m_pthr = 8'd0;
            e_dout = '0; e_de = 0; e_vs = 0; e_hs = 0; e_err = 0;
            m_pix = 0; m_widths.delete(); e_fw = '0; e_fh = '0;
        end else begin
            m_d = m_q.pop_front();
            m_q.push_back({de_in, vs_in, hs_in, rgb_in});
            m_fe  = m_d[25] && !m_prev_vs;
            m_acc = mode_req_vld && !m_has_pend;
            if (m_fe) begin
                m_active = 1;
                if (m_has_pend) begin m_mode = m_pmode; m_thr = m_pthr; m_has_pend = 0; end
            end
            if (m_acc) begin m_pmode = mode_req; m_pthr = thr_req; m_has_pend = 1; end
            m_g = m_d[23:16];
            e_dout = '0;
            if (m_active && m_d[26]) begin
                case (m_mode)
                    2'd0: e_dout = m_d[23:0];
                    2'd1: e_dout = {m_g, m_g, m_g};
                    2'd2: e_dout = (m_g > m_thr) ? 24'hFFFFFF : 24'h0;
                    default: e_dout = '0;
                endcase
            end
            e_de = m_active && m_d[26];
            e_vs = m_active && m_d[25];
            e_hs = m_active && m_d[24];
            if (m_fe) begin
                e_fw = (m_widths.size() > 0) ? W_CNT'(m_widths[0]) : '0;
                e_fh = W_CNT'(m_widths.size());
                m_widths.delete();
                m_pix = 0;
            end else if (m_prev_de && !m_d[26]) begin
                if (m_widths.size() > 0 && m_pix != m_widths[0]) e_err = 1;
                m_widths.push_back(m_pix);
                m_pix = 0;
            end else if (m_d[26]) begin
                m_pix++;
            end
            m_prev_vs = m_d[25];
            m_prev_de = m_d[26];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", dout, e_dout);
            chk("de_out", de_out, e_de);
            chk("vs_out", vs_out, e_vs);
            chk("hs_out", hs_out, e_hs);
            chk("mode_req_rdy", mode_req_rdy, !m_has_pend);
            chk("mode_cur", mode_cur, m_mode);
            chk("frame_done", frame_done, STATS ? (m_q[0][25] && !m_prev_vs) : 1'b0);
            chk("frame_w", frame_w, STATS ? e_fw : '0);
            chk("frame_h", frame_h, STATS ? e_fh : '0);
            chk("frame_err", frame_err, STATS ? e_err : 1'b0);
        end
    end

    logic [23:0] out_log[$];
    int fd_cnt = 0;
    always @(negedge clk) begin
        if (de_out) out_log.push_back(dout);
        if (frame_done) fd_cnt++;
    end

    bit          arm_vld = 0, rnd_en = 0;
    int          pmode = 0, pat_i = 0;
    logic [23:0] fix_rgb = 24'h123456;
    logic [23:0] pat [4];

    function automatic logic [23:0] pick();
        logic [23:0] v;
        if (pmode == 0) v = fix_rgb;
        else if (pmode == 1) v = 24'($urandom);
        else begin v = pat[pat_i % 4]; pat_i++; end
        return v;
    endfunction

    task automatic drive(input bit de, input bit vs, input bit hs);
        rgb_in = de ? pick() : 24'($urandom);
        de_in = de; vs_in = vs; hs_in = hs;
        if (arm_vld) mode_req_vld = 1'b1;
        else if (rnd_en) begin
            mode_req_vld = ($urandom % 6 == 0);
            mode_req = 2'($urandom);
            thr_req = 8'($urandom);
        end else mode_req_vld = 1'b0;
        @(posedge clk); #1;
        arm_vld = 0;
    endtask

    task automatic line(input int w);
        drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
        for (int i = 0; i < w; i++) drive(1, 0, 0);
        drive(0, 0, 0); drive(0, 0, 0);
    endtask

    task automatic fstart(input int req_k);
        for (int k = 0; k < FS; k++) begin
            if (k == req_k) arm_vld = 1;
            drive(0, k < 2, 0);
        end
    endtask

    task automatic flush();
        repeat (L + 1) drive(0, 0, 0);
    endtask

    task automatic chk_log(input string nm, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [23:0] e3);
        logic [23:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        chk({nm, "_count"}, out_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(nm, (i < out_log.size()) ? {8'h0, out_log[i]} : 32'hDEADBEEF, {8'h0, ev[i]});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int fd0;
    initial begin
        pat[0] = 24'h63ABCD; pat[1] = 24'h640011; pat[2] = 24'h65FF00; pat[3] = 24'hC81234;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("reset_dout", dout, 0);
        chk("reset_syncs", {de_out, vs_out, hs_out}, 0);
        chk("reset_rdy", mode_req_rdy, 1);
        chk("reset_mode", mode_cur, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Stray line before any vsync must produce nothing.
        pmode = 0; fix_rgb = 24'h123456;
        out_log.delete();
        line(4);
        flush();
        chk("pre_vs_outputs", out_log.size(), 0);

        fstart(-1); line(4); line(4); line(4);

        // Latency frame: first pixel shows up exactly L+1 cycles after de_in.
        fstart(-1);
        drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
        for (int i = 0; i <= L || i < 4; i++) begin
            drive(i < 4, 0, 0);
            if (i == L - 1) chk("latency_before", {de_out, dout}, 0);
            if (i == L) chk("latency_at", {de_out, dout}, {1'b1, 24'h123456});
        end
        drive(0, 0, 0); drive(0, 0, 0);
        line(4);
        mode_req = 2'd1; thr_req = 8'd50; arm_vld = 1;
        line(4);
        chk("gray_req_rdy_low", mode_req_rdy, 0);
        chk("gray_req_still_bypass", mode_cur, 0);

        pmode = 2; pat_i = 0;
        fstart(-1);
        chk("gray_rdy_back", mode_req_rdy, 1);
        chk("gray_mode_cur", mode_cur, 1);
        out_log.delete();
        line(4); flush();
        chk_log("gray_pix", 24'h636363, 24'h646464, 24'h656565, 24'hC8C8C8);
        mode_req = 2'd2; thr_req = 8'd100; arm_vld = 1;
        line(4); line(4);

        pat_i = 0;
        fstart(-1);
        chk("bin_mode_cur", mode_cur, 2);
        out_log.delete();
        line(4); flush();
        chk_log("bin_pix", 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF);
        line(4);

        // Request accepted on the frame-edge cycle waits one more frame.
        mode_req = 2'd3; thr_req = 8'd7;
        fstart(L);
        chk("edge_req_rdy", mode_req_rdy, 0);
        chk("edge_req_waits", mode_cur, 2);
        line(4); line(4); line(4);
        fd0 = fd_cnt;
        fstart(-1);
        chk("edge_req_applied", mode_cur, 3);
        chk("edge_req_rdy_back", mode_req_rdy, 1);
        line(4); line(4); line(4);

        fd0 = fd_cnt;
        fstart(-1);
        chk("stats_done_pulses", fd_cnt - fd0, STATS ? 1 : 0);
        chk("stats_w", frame_w, STATS ? 4 : 0);
        chk("stats_h", frame_h, STATS ? 3 : 0);
        chk("stats_err_clean", frame_err, 0);
        line(4); line(5); line(4);
        fstart(-1);
        chk("stats_err_set", frame_err, STATS ? 1 : 0);
        chk("stats_w_bad", frame_w, STATS ? 4 : 0);
        chk("stats_h_bad", frame_h, STATS ? 3 : 0);
        line(4); line(4); line(4);
        fstart(-1);
        chk("stats_err_sticky", frame_err, STATS ? 1 : 0);

        rnd_en = 1; pmode = 1;
        for (int f = 0; f < 24; f++) begin
            int h;
            fstart(-1);
            h = $urandom_range(1, 4);
            for (int j = 0; j < h; j++) line($urandom_range(2, 6));
        end
        rnd_en = 0;

        fstart(-1);
        mode_req = 2'd1; thr_req = 8'd0; arm_vld = 1;
        line(4);
        fstart(-1);
        chk("pre_reset_mode", mode_cur, 1);
        pmode = 0; fix_rgb = 24'hA55A3C;
        drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
        repeat (L + 2) drive(1, 0, 0);
        chk("pre_reset_dout", dout, 24'hA5A5A5);
        rst_n = 1'b0;
        #1;
        chk("midline_rst_dout", dout, 0);
        chk("midline_rst_syncs", {de_out, vs_out, hs_out}, 0);
        chk("midline_rst_rdy", mode_req_rdy, 1);
        chk("midline_rst_mode", mode_cur, 0);
        chk("midline_rst_stats", {frame_err, frame_w, frame_h}, 0);
        out_log.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        line(4); flush();
        chk("blank_after_reset", out_log.size(), 0);
        fstart(-1);
        line(4); flush();
        chk_log("bypass_after_reset", 24'hA55A3C, 24'hA55A3C, 24'hA55A3C, 24'hA55A3C);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
